// File: rtl/conf_bus_arbiter_sched.sv
// Round-robin arbiter sharing the CGRA configuration bus between the host loader (src0) and
// the context-reload engine (src1). Define CONF_IDLE_GAP_EN to insert one GAP cycle after every packet.
module conf_bus_arbiter_sched #(
  parameter int DATA_W       = 64,
  parameter int IDLE_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic [DATA_W-1:0] conf_bus_out,
  output logic              conf_bus_valid,
  output logic              pkt_done,
  output logic              pkt_abort,
  output logic              pkt_src,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

`ifdef CONF_IDLE_GAP_EN
  localparam state_t PKT_END_STATE = GAP;
`else
  localparam state_t PKT_END_STATE = IDLE;
`endif

  localparam logic [7:0] TIMEOUT_LAST = 8'(IDLE_TIMEOUT - 1);

  state_t            state, state_next;
  logic              rr_last, rr_next;
  logic              src_reg, src_next;
  logic [7:0]        idle_cnt, idle_cnt_next;
  logic              abort_next;
  logic              accept;
  logic              sel_valid, sel_last;
  logic [DATA_W-1:0] sel_data;

  assign s0_ready = (state == GRANT0);
  assign s1_ready = (state == GRANT1);
  assign busy     = (state != IDLE);
  assign pkt_src  = src_reg;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    if (state == GRANT0) begin
      sel_valid = s0_valid;
      sel_last  = s0_last;
      sel_data  = s0_data;
    end else if (state == GRANT1) begin
      sel_valid = s1_valid;
      sel_last  = s1_last;
      sel_data  = s1_data;
    end
  end

  assign accept = sel_valid;

  // rr_last holds the previous winner, so contention favours the other source.
  always_comb begin
    state_next    = state;
    rr_next       = rr_last;
    src_next      = src_reg;
    idle_cnt_next = idle_cnt;
    abort_next    = 1'b0;
    case (state)
      IDLE: begin
        idle_cnt_next = '0;
        if (s0_valid && (!s1_valid || rr_last)) begin
          state_next = GRANT0;
          src_next   = 1'b0;
        end else if (s1_valid) begin
          state_next = GRANT1;
          src_next   = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (accept) begin
          idle_cnt_next = '0;
          if (sel_last) begin
            state_next = PKT_END_STATE;
            rr_next    = (state == GRANT1);
          end
        end else if (idle_cnt == TIMEOUT_LAST) begin
          state_next    = IDLE;
          abort_next    = 1'b1;
          rr_next       = (state == GRANT1);
          idle_cnt_next = '0;
        end else begin
          idle_cnt_next = idle_cnt + 8'd1;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      src_reg  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      state    <= state_next;
      rr_last  <= rr_next;
      src_reg  <= src_next;
      idle_cnt <= idle_cnt_next;
    end
  end

  // Bus outputs are registered; a cycle without an accepted word drives the no-op value 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      conf_bus_out   <= '0;
      conf_bus_valid <= 1'b0;
      pkt_done       <= 1'b0;
      pkt_abort      <= 1'b0;
      words_sent     <= '0;
    end else begin
      conf_bus_out   <= accept ? sel_data : '0;
      conf_bus_valid <= accept;
      pkt_done       <= accept && sel_last;
      pkt_abort      <= abort_next;
      words_sent     <= words_sent + CNT_W'(accept);
    end
  end

endmodule

// File: tb/tb_conf_bus_arbiter_sched.sv
// Scoreboard bench for conf_bus_arbiter_sched: directed packets push expected bus words,
// a negedge monitor pops and compares every word the DUT puts on the bus.
module tb_conf_bus_arbiter_sched;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;
`ifdef CONF_IDLE_GAP_EN
  localparam int EXP_B2B_GAP = 3;
`else
  localparam int EXP_B2B_GAP = 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] s0_data, s1_data;
  logic              s0_valid, s0_last, s0_ready;
  logic              s1_valid, s1_last, s1_ready;
  logic [DATA_W-1:0] conf_bus_out;
  logic              conf_bus_valid, pkt_done, pkt_abort, pkt_src, busy;
  logic [CNT_W-1:0]  words_sent;

  conf_bus_arbiter_sched #(.DATA_W(DATA_W), .IDLE_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .conf_bus_out(conf_bus_out), .conf_bus_valid(conf_bus_valid),
    .pkt_done(pkt_done), .pkt_abort(pkt_abort), .pkt_src(pkt_src),
    .busy(busy), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              done;
    logic              src;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;
  int   last_gap = 0;
  int   abort_count = 0;
  int   abort_cyc = 0;
  logic busy_at_abort = 1'b1;
  int   accept_cyc = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic done, input logic src);
    exp_t e;
    e.data = d;
    e.done = done;
    e.src  = src;
    sb.push_back(e);
  endtask

  task automatic drive(input int src, input logic v, input logic [DATA_W-1:0] d, input logic l);
    if (src == 0) begin
      s0_valid = v; s0_data = d; s0_last = l;
    end else begin
      s1_valid = v; s1_data = d; s1_last = l;
    end
  endtask

  // Sends an n-word packet on one source, holding valid low for gap cycles between words.
  task automatic applyStimulus(input int src, input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                               input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3,
                               input int n, input int gap);
    logic [DATA_W-1:0] w;
    bit got;
    for (int i = 0; i < n; i++) begin
      case (i)
        0:       w = w0;
        1:       w = w1;
        2:       w = w2;
        default: w = w3;
      endcase
      drive(src, 1'b1, w, (i == n - 1));
      got = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if ((src == 0 && s0_ready) || (src == 1 && s1_ready)) begin
          got = 1;
          break;
        end
      end
      if (!got) begin
        checks++;
        errors++;
        $display("[TB] FAIL ready_timeout src%0d word %0d: got no ready expected ready", src, i);
        drive(src, 1'b0, '0, 1'b0);
        return;
      end
      @(posedge clk); #1;
      drive(src, 1'b0, '0, 1'b0);
      if (i < n - 1 && gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s drain: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Monitor: every valid bus word must match the head of the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (conf_bus_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got %h expected no word", conf_bus_out);
      end else begin
        e = sb.pop_front();
        checkOutput("bus_data", conf_bus_out, e.data);
        checkOutput("bus_done", 64'(pkt_done), 64'(e.done));
        checkOutput("bus_src", 64'(pkt_src), 64'(e.src));
      end
      last_gap = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
    end else begin
      checkOutput("idle_bus_zero", conf_bus_out, 64'd0);
      checkOutput("idle_no_done", 64'(pkt_done), 64'd0);
    end
    if (pkt_abort) begin
      abort_count++;
      abort_cyc = cyc;
      busy_at_abort = busy;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_bus", conf_bus_out, 64'd0);
    checkOutput("rst_valid", 64'(conf_bus_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_words", 64'(words_sent), 64'd0);
    checkOutput("rst_src", 64'(pkt_src), 64'd0);
    checkOutput("rst_abort", 64'(pkt_abort), 64'd0);
    checkOutput("rst_ready0", 64'(s0_ready), 64'd0);
    checkOutput("rst_ready1", 64'(s1_ready), 64'd0);

    // 3-word src0 packet with exact cycle timing
    $display("[TB] src0 3-word packet");
    push_exp(64'hA1, 1'b0, 1'b0);
    push_exp(64'hA2, 1'b0, 1'b0);
    push_exp(64'hA3, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 64'hA1, 1'b0);
    @(negedge clk);
    checkOutput("t1_ready_arb", 64'(s0_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t1_ready_grant", 64'(s0_ready), 64'd1);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    checkOutput("t1_ready1_low", 64'(s1_ready), 64'd0);
    @(posedge clk); #1;
    drive(0, 1'b1, 64'hA2, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 64'hA3, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, 1'b0);
    wait_drain("t1");
    checkOutput("t1_words", 64'(words_sent), 64'd3);
    checkOutput("t1_idle", 64'(busy), 64'd0);
    checkOutput("t1_no_abort", 64'(abort_count), 64'd0);

    // Round-robin with both sources contending from reset
    $display("[TB] round-robin contention");
    do_reset();
    push_exp(64'hB0A, 1'b1, 1'b0);
    push_exp(64'hB1A, 1'b1, 1'b1);
    push_exp(64'hB0B, 1'b1, 1'b0);
    push_exp(64'hB1B, 1'b1, 1'b1);
    fork
      begin
        applyStimulus(0, 64'hB0A, 0, 0, 0, 1, 0);
        applyStimulus(0, 64'hB0B, 0, 0, 0, 1, 0);
      end
      begin
        applyStimulus(1, 64'hB1A, 0, 0, 0, 1, 0);
        applyStimulus(1, 64'hB1B, 0, 0, 0, 1, 0);
      end
    join
    wait_drain("t2");
    checkOutput("t2_words", 64'(words_sent), 64'd4);
    checkOutput("t2_last_src", 64'(pkt_src), 64'd1);

    // src1 packet with a 5-cycle stall between words, well under the timeout
    $display("[TB] src1 stalled packet");
    push_exp(64'hC0, 1'b0, 1'b1);
    push_exp(64'hC1, 1'b1, 1'b1);
    applyStimulus(1, 64'hC0, 64'hC1, 0, 0, 2, 5);
    wait_drain("t3");
    checkOutput("t3_gap", 64'(last_gap), 64'd6);
    checkOutput("t3_no_abort", 64'(abort_count), 64'd0);
    checkOutput("t3_words", 64'(words_sent), 64'd6);

    // src0 stalls after one word: timeout abort, then waiting src1 is served
    $display("[TB] timeout abort");
    abort_count = 0;
    abort_cyc = 0;
    push_exp(64'hD0, 1'b0, 1'b0);
    push_exp(64'hE0, 1'b1, 1'b1);
    drive(0, 1'b1, 64'hD0, 1'b0);
    for (int k = 0; k < 50 && !s0_ready; k++) @(negedge clk);
    @(posedge clk); #1;
    accept_cyc = cyc;
    drive(0, 1'b0, '0, 1'b0);
    applyStimulus(1, 64'hE0, 0, 0, 0, 1, 0);
    wait_drain("t4");
    checkOutput("t4_abort_count", 64'(abort_count), 64'd1);
    checkOutput("t4_abort_delay", 64'(abort_cyc - accept_cyc), 64'd16);
    checkOutput("t4_busy_at_abort", 64'(busy_at_abort), 64'd0);

    // Reset in the middle of a 4-word packet
    $display("[TB] reset mid-packet");
    push_exp(64'hF0, 1'b0, 1'b0);
    drive(0, 1'b1, 64'hF0, 1'b0);
    for (int k = 0; k < 50 && !s0_ready; k++) @(negedge clk);
    @(posedge clk); #1;
    drive(0, 1'b1, 64'hF1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_bus", conf_bus_out, 64'd0);
    checkOutput("t5_valid", 64'(conf_bus_valid), 64'd0);
    checkOutput("t5_words", 64'(words_sent), 64'd0);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    checkOutput("t5_src", 64'(pkt_src), 64'd0);
    checkOutput("t5_ready", 64'(s0_ready), 64'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    wait_drain("t5");

    // Back-to-back src0 packets: idle bus cycles between them
    $display("[TB] back-to-back packets");
    push_exp(64'h60, 1'b0, 1'b0);
    push_exp(64'h61, 1'b1, 1'b0);
    push_exp(64'h70, 1'b1, 1'b0);
    applyStimulus(0, 64'h60, 64'h61, 0, 0, 2, 0);
    applyStimulus(0, 64'h70, 0, 0, 0, 1, 0);
    wait_drain("t6");
    checkOutput("t6_gap", 64'(last_gap), 64'(EXP_B2B_GAP));
    checkOutput("t6_words", 64'(words_sent), 64'd3);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
